// File: rtl/tone_monitor_if.sv
// Tone monitor bus: per-channel sample strobes and data, check limits,
// statistics clear, and the per-channel measurement results.
interface tone_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12,
    parameter int ERR_W  = 8
);
    logic [NUM_CH-1:0]             smp_vld;
    logic [NUM_CH-1:0][DATA_W-1:0] smp_data;
    logic                          clr_stats;
    logic [CNT_W-1:0]              min_period;
    logic [CNT_W-1:0]              max_period;
    logic [DATA_W-1:0]             min_ampl;
    logic [DATA_W-1:0]             max_ampl;
    logic [NUM_CH-1:0]             meas_vld;
    logic [NUM_CH-1:0][CNT_W-1:0]  period;
    logic [NUM_CH-1:0][DATA_W-1:0] peak;
    logic [NUM_CH-1:0][ERR_W-1:0]  freq_err;
    logic [NUM_CH-1:0][ERR_W-1:0]  ampl_err;
    logic [NUM_CH-1:0]             locked;

    modport master (
        output smp_vld, smp_data, clr_stats, min_period, max_period, min_ampl, max_ampl,
        input  meas_vld, period, peak, freq_err, ampl_err, locked
    );
    modport slave (
        input  smp_vld, smp_data, clr_stats, min_period, max_period, min_ampl, max_ampl,
        output meas_vld, period, peak, freq_err, ampl_err, locked
    );
endinterface

// File: rtl/tone_monitor.sv
// Per-channel audio tone checker: moving-average smoother, negative-to-positive
// zero-crossing detector, period counter and peak tracker, with saturating
// period/amplitude error counts checked against programmable limits.

// One channel of the tone monitor.
module tone_monitor_ch #(
    parameter int DATA_W    = 16,
    parameter int AVG_LOG2  = 2,
    parameter int CNT_W     = 12,
    parameter int ERR_W     = 8,
    parameter int SKIP_XING = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     smp_vld,
    input  logic signed [DATA_W-1:0] smp_data,
    input  logic                     clr_stats,
    input  logic        [CNT_W-1:0]  min_period,
    input  logic        [CNT_W-1:0]  max_period,
    input  logic signed [DATA_W-1:0] min_ampl,
    input  logic signed [DATA_W-1:0] max_ampl,
    output logic                     meas_vld,
    output logic        [CNT_W-1:0]  period,
    output logic signed [DATA_W-1:0] peak,
    output logic        [ERR_W-1:0]  freq_err,
    output logic        [ERR_W-1:0]  ampl_err,
    output logic                     locked
);
    localparam int TAPS   = 1 << AVG_LOG2;
    localparam int SUM_W  = DATA_W + AVG_LOG2;
    localparam int XC_W   = $clog2(SKIP_XING + 2);
    localparam int STAGES = 1;

    // vld_pipe[0]: window/sum updated, average pending; vld_pipe[1]: average ready for evaluation
    logic [STAGES:0]              vld_pipe;
    logic [TAPS-1:0][DATA_W-1:0]  win;
    logic signed [SUM_W-1:0]      sum;
    logic signed [DATA_W-1:0]     avg;
    logic signed [DATA_W-1:0]     avg_prev;
    logic        [CNT_W-1:0]      cnt;
    logic signed [DATA_W-1:0]     pk;
    logic        [XC_W-1:0]       xcnt;

    logic                         xing;
    logic                         cnt_sat;
    logic                         checked;
    logic                         p_bad;
    logic                         a_bad;
    logic        [CNT_W-1:0]      p_meas;
    logic signed [DATA_W-1:0]     k_meas;

    // Smoother datapath: only reset touches it, so clr_stats never disturbs the settled average
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            win      <= '0;
            sum      <= '0;
            avg      <= '0;
            avg_prev <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], smp_vld};
            if (smp_vld) begin
                win <= {win[TAPS-2:0], smp_data};
                sum <= sum + SUM_W'(smp_data) - SUM_W'($signed(win[TAPS-1]));
            end
            if (vld_pipe[0]) begin
                avg      <= DATA_W'(sum >>> AVG_LOG2);
                avg_prev <= avg;
            end
        end
    end

    // Crossing detection and the measurement that a crossing would report
    always_comb begin
        xing    = avg_prev[DATA_W-1] & ~avg[DATA_W-1];
        cnt_sat = &cnt;
        p_meas  = cnt_sat ? cnt : cnt + CNT_W'(1);
        k_meas  = (avg > pk) ? avg : pk;
        checked = (xcnt >= XC_W'(SKIP_XING));
        p_bad   = (p_meas < min_period) | (p_meas > max_period) | cnt_sat;
        a_bad   = (k_meas < min_ampl) | (k_meas > max_ampl);
    end

    assign locked = checked;

    // Period/peak tracking and error accounting; a clear on the evaluation edge wins
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            meas_vld <= 1'b0;
            period   <= '0;
            peak     <= '0;
            freq_err <= '0;
            ampl_err <= '0;
            cnt      <= '0;
            pk       <= '0;
            xcnt     <= '0;
        end else begin
            meas_vld <= 1'b0;
            if (vld_pipe[1]) begin
                if (!xing) begin
                    if (!cnt_sat) cnt <= cnt + CNT_W'(1);
                    pk <= k_meas;
                end else begin
                    cnt <= '0;
                    pk  <= '0;
                    if (xcnt < XC_W'(SKIP_XING + 1)) xcnt <= xcnt + XC_W'(1);
                    if (checked) begin
                        meas_vld <= 1'b1;
                        period   <= p_meas;
                        peak     <= k_meas;
                        if (p_bad && !(&freq_err)) freq_err <= freq_err + ERR_W'(1);
                        if (a_bad && !(&ampl_err)) ampl_err <= ampl_err + ERR_W'(1);
                    end
                end
            end
        end
    end
endmodule

// Top: one independent monitor per channel, all sharing the limits and clear.
module tone_monitor #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 16,
    parameter int AVG_LOG2  = 2,
    parameter int CNT_W     = 12,
    parameter int ERR_W     = 8,
    parameter int SKIP_XING = 2
) (
    input logic           clk,
    input logic           rst,
    tone_monitor_if.slave bus
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tone_monitor_ch #(
            .DATA_W    (DATA_W),
            .AVG_LOG2  (AVG_LOG2),
            .CNT_W     (CNT_W),
            .ERR_W     (ERR_W),
            .SKIP_XING (SKIP_XING)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .smp_vld    (bus.smp_vld[c]),
            .smp_data   (bus.smp_data[c]),
            .clr_stats  (bus.clr_stats),
            .min_period (bus.min_period),
            .max_period (bus.max_period),
            .min_ampl   (bus.min_ampl),
            .max_ampl   (bus.max_ampl),
            .meas_vld   (bus.meas_vld[c]),
            .period     (bus.period[c]),
            .peak       (bus.peak[c]),
            .freq_err   (bus.freq_err[c]),
            .ampl_err   (bus.ampl_err[c]),
            .locked     (bus.locked[c])
        );
    end
endmodule

// File: tb/tb_tone_monitor.sv
// Bench for tone_monitor: two instances (default crossing skip, and no skip)
// share one stimulus stream; a sample-level reference model predicts every
// reported measurement and the final statistics of each phase.
module tb_tone_monitor;
    localparam int NUM_CH  = 2;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 12;
    localparam int ERR_W   = 8;
    localparam int NDUT    = 2;
    localparam int TAPS    = 4;
    localparam int CNT_MAX = 4095;
    localparam int ERR_MAX = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tone_monitor_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus_a ();
    tone_monitor_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus_b ();

    assign bus_b.smp_vld    = bus_a.smp_vld;
    assign bus_b.smp_data   = bus_a.smp_data;
    assign bus_b.clr_stats  = bus_a.clr_stats;
    assign bus_b.min_period = bus_a.min_period;
    assign bus_b.max_period = bus_a.max_period;
    assign bus_b.min_ampl   = bus_a.min_ampl;
    assign bus_b.max_ampl   = bus_a.max_ampl;

    tone_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(2), .CNT_W(CNT_W),
                   .ERR_W(ERR_W), .SKIP_XING(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    tone_monitor #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .AVG_LOG2(2), .CNT_W(CNT_W),
                   .ERR_W(ERR_W), .SKIP_XING(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // reference model state, index d*NUM_CH+c
    int win [4][TAPS];
    int m_avg [4], m_cnt [4], m_pk [4], m_xcnt [4];
    int m_period [4], m_peak [4], m_ferr [4], m_aerr [4];
    int exp_per [4][$];
    int exp_pk  [4][$];
    int last_xing [NUM_CH];
    int lim_minp, lim_maxp, lim_mina, lim_maxa;

    function automatic int skip_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < TAPS; t++) win[i][t] = 0;
            m_avg[i] = 0; m_cnt[i] = 0; m_pk[i] = 0; m_xcnt[i] = 0;
            m_period[i] = 0; m_peak[i] = 0; m_ferr[i] = 0; m_aerr[i] = 0;
            exp_per[i].delete(); exp_pk[i].delete();
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_pk[i] = 0; m_xcnt[i] = 0;
            m_period[i] = 0; m_peak[i] = 0; m_ferr[i] = 0; m_aerr[i] = 0;
            exp_per[i].delete(); exp_pk[i].delete();
        end
    endtask

    // one accepted sample on channel c, for both instances
    task automatic model_step(input int c, input int x);
        int i, s, a, prev, p, k, was, xg;
        for (int d = 0; d < NDUT; d++) begin
            i = d * NUM_CH + c;
            for (int t = TAPS - 1; t > 0; t--) win[i][t] = win[i][t-1];
            win[i][0] = x;
            s = 0;
            for (int t = 0; t < TAPS; t++) s += win[i][t];
            a = (s >= 0) ? s / TAPS : -((-s + TAPS - 1) / TAPS);  // floor division
            prev = m_avg[i];
            m_avg[i] = a;
            k = (a > m_pk[i]) ? a : m_pk[i];
            xg = (prev < 0 && a >= 0) ? 1 : 0;
            if (xg == 0) begin
                if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                m_pk[i] = k;
            end else begin
                p = (m_cnt[i] == CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
                was = m_xcnt[i];
                if (m_xcnt[i] < skip_of(d) + 1) m_xcnt[i]++;
                if (was >= skip_of(d)) begin
                    m_period[i] = p;
                    m_peak[i] = k;
                    exp_per[i].push_back(p);
                    exp_pk[i].push_back(k);
                    if ((p < lim_minp || p > lim_maxp || m_cnt[i] == CNT_MAX) && m_ferr[i] < ERR_MAX)
                        m_ferr[i]++;
                    if ((k < lim_mina || k > lim_maxa) && m_aerr[i] < ERR_MAX)
                        m_aerr[i]++;
                end
                m_cnt[i] = 0;
                m_pk[i] = 0;
            end
            if (d == 0) last_xing[c] = xg;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] v, input int x0, input int x1);
        bus_a.smp_vld     = v;
        bus_a.smp_data[0] = DATA_W'(x0);
        bus_a.smp_data[1] = DATA_W'(x1);
        last_xing[0] = 0;
        last_xing[1] = 0;
        if (v[0]) model_step(0, x0);
        if (v[1]) model_step(1, x1);
        @(posedge clk);
        #1;
        bus_a.smp_vld = '0;
    endtask

    task automatic set_lim(input int minp, input int maxp, input int mina, input int maxa);
        lim_minp = minp; lim_maxp = maxp; lim_mina = mina; lim_maxa = maxa;
        bus_a.min_period = CNT_W'(minp);
        bus_a.max_period = CNT_W'(maxp);
        bus_a.min_ampl   = DATA_W'(mina);
        bus_a.max_ampl   = DATA_W'(maxa);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int wave(input int n, input int per, input int amp);
        return ((n % per) < per / 2) ? -amp : amp;
    endfunction

    // flush the pipeline, then compare every statistic of both instances to the model
    task automatic check_all(input string tag);
        int i, per, pk, fe, ae, lk;
        idle(4);
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                i = d * NUM_CH + c;
                if (d == 0) begin
                    per = int'(bus_a.period[c]);   pk = int'($signed(bus_a.peak[c]));
                    fe  = int'(bus_a.freq_err[c]); ae = int'(bus_a.ampl_err[c]);
                    lk  = int'(bus_a.locked[c]);
                end else begin
                    per = int'(bus_b.period[c]);   pk = int'($signed(bus_b.peak[c]));
                    fe  = int'(bus_b.freq_err[c]); ae = int'(bus_b.ampl_err[c]);
                    lk  = int'(bus_b.locked[c]);
                end
                chk($sformatf("%s.d%0d.c%0d.period", tag, d, c), per, m_period[i]);
                chk($sformatf("%s.d%0d.c%0d.peak", tag, d, c), pk, m_peak[i]);
                chk($sformatf("%s.d%0d.c%0d.freq_err", tag, d, c), fe, m_ferr[i]);
                chk($sformatf("%s.d%0d.c%0d.ampl_err", tag, d, c), ae, m_aerr[i]);
                chk($sformatf("%s.d%0d.c%0d.locked", tag, d, c), lk,
                    (m_xcnt[i] >= skip_of(d)) ? 1 : 0);
                chk($sformatf("%s.d%0d.c%0d.missing_meas", tag, d, c), exp_per[i].size(), 0);
            end
        end
    endtask

    // every measurement pulse must match the next predicted one
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int i, mv, per, pk;
                i   = d * NUM_CH + c;
                mv  = (d == 0) ? int'(bus_a.meas_vld[c]) : int'(bus_b.meas_vld[c]);
                per = (d == 0) ? int'(bus_a.period[c]) : int'(bus_b.period[c]);
                pk  = (d == 0) ? int'($signed(bus_a.peak[c])) : int'($signed(bus_b.peak[c]));
                if (mv == 1) begin
                    if (exp_per[i].size() == 0) begin
                        chk($sformatf("unexpected_meas.d%0d.c%0d", d, c), 1, 0);
                    end else begin
                        chk($sformatf("meas_period.d%0d.c%0d", d, c), per, exp_per[i].pop_front());
                        chk($sformatf("meas_peak.d%0d.c%0d", d, c), pk, exp_pk[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, p0, p1, a0, a1, guard;
        logic [1:0] v;
        bus_a.smp_vld   = '0;
        bus_a.smp_data  = '0;
        bus_a.clr_stats = 1'b0;
        set_lim(115, 185, 2400, 4000);
        rst = 1'b1;
        model_reset();
        idle(2);
        rst = 1'b0;

        // reset state
        check_all("reset");
        chk("reset.a.locked_bits", int'(bus_a.locked), 0);
        chk("reset.a.meas_vld_bits", int'(bus_a.meas_vld), 0);

        // ch0 period 153, ch1 period 100, strobed together every cycle
        for (int n = 0; n < 153 * 6; n++) send(2'b11, wave(n, 153, 3200), wave(n, 100, 3200));
        check_all("dual");
        chk("dual.a.c0.period", int'(bus_a.period[0]), 153);
        chk("dual.a.c0.peak", int'($signed(bus_a.peak[0])), 3200);
        chk("dual.a.c0.freq_err", int'(bus_a.freq_err[0]), 0);

        // overdriven amplitude on ch0, random strobe gaps on both channels
        do_reset();
        n0 = 0; n1 = 0;
        while (n0 < 153 * 5) begin
            v[0] = ($urandom_range(3) != 0);
            v[1] = ($urandom_range(3) != 0);
            send(v, wave(n0, 153, 5000), wave(n1, 153, 3200));
            if (v[0]) n0++;
            if (v[1]) n1++;
        end
        check_all("loud");
        chk("loud.a.c0.peak", int'($signed(bus_a.peak[0])), 5000);

        // random periods, amplitudes and noise
        do_reset();
        p0 = $urandom_range(60, 200); p1 = $urandom_range(60, 200);
        a0 = $urandom_range(1000, 6000); a1 = $urandom_range(1000, 6000);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 1500; k++) begin
            v[0] = ($urandom_range(4) != 0);
            v[1] = ($urandom_range(4) != 0);
            send(v, wave(n0, p0, a0) + int'($urandom_range(40)) - 20,
                    wave(n1, p1, a1) + int'($urandom_range(40)) - 20);
            if (v[0]) n0++;
            if (v[1]) n1++;
        end
        check_all("random");

        // long DC run saturates the period counter before the single crossing
        do_reset();
        for (int n = 0; n < 5000; n++) send(2'b11, -100, -100);
        for (int n = 0; n < 10; n++) send(2'b11, 100, 100);
        check_all("dc");
        chk("dc.a.c0.period", int'(bus_a.period[0]), 0);
        chk("dc.b.c0.period", int'(bus_b.period[0]), CNT_MAX);
        chk("dc.b.c0.freq_err", int'(bus_b.freq_err[0]), 1);

        // 300 too-short periods saturate the frequency error count
        do_reset();
        for (int n = 0; n < 100 * 300; n++) send(2'b11, wave(n, 100, 3200), wave(n, 100, 3200));
        check_all("sat");
        chk("sat.a.c0.freq_err", int'(bus_a.freq_err[0]), ERR_MAX);

        // clear landing on the evaluation edge of a crossing
        guard = 0;
        n0 = 100 * 300;
        last_xing[0] = 0;
        while (last_xing[0] == 0 && guard < 300) begin
            send(2'b11, wave(n0, 100, 3200), wave(n0, 100, 3200));
            n0++;
            guard++;
        end
        chk("clr.found_xing", last_xing[0], 1);
        @(posedge clk);
        #1;
        bus_a.clr_stats = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        bus_a.clr_stats = 1'b0;
        check_all("clr");
        chk("clr.a.c0.locked", int'(bus_a.locked[0]), 0);
        for (int k = 0; k < 100 * 3 + 10; k++) begin
            send(2'b11, wave(n0, 100, 3200), wave(n0, 100, 3200));
            n0++;
        end
        check_all("post_clr");

        // reset in the middle of a period, then the wave resumes
        do_reset();
        for (int n = 0; n < 230; n++) send(2'b11, wave(n, 153, 3200), wave(n, 153, 3200));
        idle(4);
        do_reset();
        check_all("midrst");
        chk("midrst.a.c0.period", int'(bus_a.period[0]), 0);
        for (int n = 230; n < 230 + 153 * 5; n++)
            send(2'b11, wave(n, 153, 3200), wave(n, 153, 3200));
        check_all("resume");
        chk("resume.a.c0.period", int'(bus_a.period[0]), 153);
        chk("resume.a.c0.locked", int'(bus_a.locked[0]), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
